// File: rtl/add_s_pkg.sv
// add_s_pkg: shared limits and status-flag bundle for the signed adder
package add_s_pkg;

    typedef struct packed {
        logic pos;
        logic neg;
        logic zero;
        logic ovf;
    } flags_t;

    localparam flags_t FLAGS_RST = '{pos: 1'b0, neg: 1'b0, zero: 1'b1, ovf: 1'b0};

    function automatic logic [31:0] smax(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] smin(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/add_s_full_adder.sv
// full_adder: one-bit full adder cell for the ripple-carry chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add_s.sv
// add_s: registered signed adder with optional saturation and sign/zero/overflow flags
module add_s
    import add_s_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic signed [WIDTH-1:0] C,
    output logic                    pos,
    output logic                    neg,
    output logic                    zero,
    output logic                    ovf
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(smin(WIDTH));

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c_d, c_q;
    logic             ovf_d;
    flags_t           flags_d, flags_q;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (A[i]),
            .b   (B[i]),
            .cin (carry[i]),
            .s   (s[i]),
            .cout(carry[i+1])
        );
    end

    // carry into the MSB disagreeing with carry out of it marks signed overflow
    assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

    always_comb begin
        c_d          = (SATURATE && ovf_d) ? (A[WIDTH-1] ? MIN_C : MAX_C) : s;
        flags_d.neg  = c_d[WIDTH-1];
        flags_d.zero = ~|c_d;
        flags_d.pos  = ~flags_d.neg & ~flags_d.zero;
        flags_d.ovf  = ovf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    assign C    = c_q;
    assign pos  = flags_q.pos;
    assign neg  = flags_q.neg;
    assign zero = flags_q.zero;
    assign ovf  = flags_q.ovf;
endmodule

// File: tb/tb_add_s.sv
// tb_add_s: randomized and directed checks of add_s at WIDTH=4, wrap and saturate instances
module tb_add_s;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [3:0] a = '0, b = '0;
    logic signed [3:0] c0, c1;
    logic              p0, n0, z0, o0, p1, n1, z1, o1;
    int                checks = 0, errors = 0;

    always #5 clk = ~clk;

    add_s #(.WIDTH(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b),
        .C(c0), .pos(p0), .neg(n0), .zero(z0), .ovf(o0)
    );

    add_s #(.WIDTH(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b),
        .C(c1), .pos(p1), .neg(n1), .zero(z1), .ovf(o1)
    );

    // reference: true integer sum, then wrap into [-8,7] or clamp to it
    function automatic logic [7:0] model(input int x, input int y, input bit sat);
        int  sum, r;
        bit  v;
        sum = x + y;
        v   = (sum > 7) || (sum < -8);
        r   = sat ? ((sum > 7) ? 7 : ((sum < -8) ? -8 : sum))
                  : ((((sum + 8) % 16) + 16) % 16) - 8;
        return {4'(r), r > 0, r < 0, r == 0, v};
    endfunction

    task automatic apply(input int x, input int y);
        @(negedge clk);
        a = 4'(x);
        b = 4'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a = 4'sd3;
        b = 4'sd2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({c0, p0, n0, z0, o0, c1, p1, n1, z1, o1} !== {8'b0000_0010, 8'b0000_0010}) begin
            errors++;
            $display("FAIL reset_hold got=%h/%h exp=02/02", {c0, p0, n0, z0, o0}, {c1, p1, n1, z1, o1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({c0, p0, n0, z0, o0} !== 8'b0101_1000) begin
            errors++;
            $display("FAIL reset_release got=%h exp=58", {c0, p0, n0, z0, o0});
        end
        apply(-3, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c0, p0, n0, z0, o0, c1, p1, n1, z1, o1} !== {8'b0000_0010, 8'b0000_0010}) begin
            errors++;
            $display("FAIL reset_async got=%h/%h exp=02/02", {c0, p0, n0, z0, o0}, {c1, p1, n1, z1, o1});
        end
        @(negedge clk);
        a = 4'sd2;
        b = 4'sd3;
        @(posedge clk);
        #1;
        checks++;
        if ({c0, p0, n0, z0, o0} !== 8'b0000_0010) begin
            errors++;
            $display("FAIL reset_held_edge got=%h exp=02", {c0, p0, n0, z0, o0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = -4'sd5;
        b = 4'sd2;
        @(posedge clk);
        #1;
        checks++;
        if ({c0, p0, n0, z0, o0, c1, p1, n1, z1, o1} !== {8'b1101_0100, 8'b1101_0100}) begin
            errors++;
            $display("FAIL reset_first_sample got=%h/%h exp=d4/d4", {c0, p0, n0, z0, o0}, {c1, p1, n1, z1, o1});
        end
    endtask

    task automatic test_sweep;
        for (int y = 7; y >= -8; y--) begin
            apply(7, y);
            checks++;
            if ({c0, p0, n0, z0, o0} !== model(7, y, 1'b0)) begin
                errors++;
                $display("FAIL sweep b=%0d got=%h exp=%h", y, {c0, p0, n0, z0, o0}, model(7, y, 1'b0));
            end
        end
    endtask

    typedef struct {int x; int y; int cw; int ow; int cs; int os;} corner_t;

    task automatic test_corners;
        corner_t t[11] = '{
            '{ 7,  7, -2, 1,  7, 1}, '{ 7,  1, -8, 1,  7, 1}, '{ 7,  0,  7, 0,  7, 0},
            '{ 7, -7,  0, 0,  0, 0}, '{ 7, -8, -1, 0, -1, 0}, '{-7,  7,  0, 0,  0, 0},
            '{-8, -8,  0, 1, -8, 1}, '{ 6,  5, -5, 1,  7, 1}, '{-4, -3, -7, 0, -7, 0},
            '{ 4,  3,  7, 0,  7, 0}, '{-1,  1,  0, 0,  0, 0}};
        foreach (t[i]) begin
            apply(t[i].x, t[i].y);
            checks++;
            if ({c0, p0, n0, z0, o0} !== {4'(t[i].cw), t[i].cw > 0, t[i].cw < 0, t[i].cw == 0, 1'(t[i].ow)}) begin
                errors++;
                $display("FAIL corner_wrap %0d+%0d got C=%0d ovf=%b exp C=%0d ovf=%0d", t[i].x, t[i].y, c0, o0, t[i].cw, t[i].ow);
            end
            checks++;
            if ({c1, p1, n1, z1, o1} !== {4'(t[i].cs), t[i].cs > 0, t[i].cs < 0, t[i].cs == 0, 1'(t[i].os)}) begin
                errors++;
                $display("FAIL corner_sat %0d+%0d got C=%0d ovf=%b exp C=%0d ovf=%0d", t[i].x, t[i].y, c1, o1, t[i].cs, t[i].os);
            end
        end
    endtask

    task automatic test_exhaustive;
        for (int x = -8; x <= 7; x++) begin
            for (int y = -8; y <= 7; y++) begin
                apply(x, y);
                checks++;
                if ({c0, p0, n0, z0, o0} !== model(x, y, 1'b0) || {c1, p1, n1, z1, o1} !== model(x, y, 1'b1)) begin
                    errors++;
                    $display("FAIL exhaustive %0d+%0d got=%h/%h exp=%h/%h", x, y,
                             {c0, p0, n0, z0, o0}, {c1, p1, n1, z1, o1}, model(x, y, 1'b0), model(x, y, 1'b1));
                end
                checks++;
                if ($countones({p0, n0, z0}) != 1 || $countones({p1, n1, z1}) != 1) begin
                    errors++;
                    $display("FAIL onehot got=%b/%b exp one bit set", {p0, n0, z0}, {p1, n1, z1});
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int pa, pb;
        @(posedge clk);
        #1;
        pa = int'($urandom_range(15)) - 8;
        pb = int'($urandom_range(15)) - 8;
        a  = 4'(pa);
        b  = 4'(pb);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({c0, p0, n0, z0, o0} !== model(pa, pb, 1'b0) || {c1, p1, n1, z1, o1} !== model(pa, pb, 1'b1)) begin
                errors++;
                $display("FAIL back_to_back %0d+%0d got=%h/%h exp=%h/%h", pa, pb,
                         {c0, p0, n0, z0, o0}, {c1, p1, n1, z1, o1}, model(pa, pb, 1'b0), model(pa, pb, 1'b1));
            end
            checks++;
            if ($countones({p0, n0, z0}) != 1 || $countones({p1, n1, z1}) != 1) begin
                errors++;
                $display("FAIL onehot got=%b/%b exp one bit set", {p0, n0, z0}, {p1, n1, z1});
            end
            pa = int'($urandom_range(15)) - 8;
            pb = int'($urandom_range(15)) - 8;
            a  = 4'(pa);
            b  = 4'(pb);
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_corners;
        test_exhaustive;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
